// File: rtl/pe_sequencer.sv
// Schedule controller for one bit-serial PDE processing element: per iteration a
// boundary-load phase and a compute phase, each closed by a word commit, then a solution readout.
module pe_sequencer #(
  parameter int WORD_W = 8,
  parameter int ITER_W = 8
) (
  input  logic                        clka,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ITER_W-1:0]           num_iter,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        pe_mode,
  output logic                        pe_read,
  output logic                        bit_en,
  output logic                        word_en,
  output logic [$clog2(WORD_W)-1:0]   bit_idx,
  output logic                        bnd_rd,
  output logic                        sol_valid,
  output logic [ITER_W-1:0]           iter_cnt
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [BIT_W-1:0] IDX_TOP = BIT_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LCOMMIT,
    S_COMP,
    S_CCOMMIT,
    S_READOUT
  } state_t;

  state_t            state;
  logic              pending;
  logic [ITER_W-1:0] num_q;

  // An accepted start first sets 'pending' so the first LOAD cycle appears one
  // cycle after the sampling edge; every output is registered alongside the state.
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      num_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pe_mode   <= 1'b0;
      pe_read   <= 1'b0;
      bit_en    <= 1'b0;
      word_en   <= 1'b0;
      bnd_rd    <= 1'b0;
      sol_valid <= 1'b0;
      bit_idx   <= IDX_TOP;
      iter_cnt  <= '0;
    end else if (abort) begin
      // iter_cnt is deliberately kept so the host can see how far the solve got.
      state     <= S_IDLE;
      pending   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pe_mode   <= 1'b0;
      pe_read   <= 1'b0;
      bit_en    <= 1'b0;
      word_en   <= 1'b0;
      bnd_rd    <= 1'b0;
      sol_valid <= 1'b0;
      bit_idx   <= IDX_TOP;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pending) begin
            pending  <= 1'b0;
            busy     <= 1'b1;
            bit_idx  <= IDX_TOP;
            iter_cnt <= '0;
            if (num_q != '0) begin
              state   <= S_LOAD;
              pe_mode <= 1'b1;
              bit_en  <= 1'b1;
              bnd_rd  <= 1'b1;
            end else begin
              state     <= S_READOUT;
              pe_read   <= 1'b1;
              word_en   <= 1'b1;
              sol_valid <= 1'b1;
            end
          end else if (start) begin
            pending <= 1'b1;
            num_q   <= num_iter;
          end
        end
        S_LOAD: begin
          if (bit_idx == '0) begin
            state   <= S_LCOMMIT;
            bit_en  <= 1'b0;
            bnd_rd  <= 1'b0;
            word_en <= 1'b1;
          end else begin
            bit_idx <= bit_idx - BIT_W'(1);
          end
        end
        S_LCOMMIT: begin
          state   <= S_COMP;
          word_en <= 1'b0;
          pe_mode <= 1'b0;
          bit_en  <= 1'b1;
          bit_idx <= IDX_TOP;
        end
        S_COMP: begin
          if (bit_idx == '0) begin
            state    <= S_CCOMMIT;
            bit_en   <= 1'b0;
            word_en  <= 1'b1;
            iter_cnt <= iter_cnt + ITER_W'(1);
          end else begin
            bit_idx <= bit_idx - BIT_W'(1);
          end
        end
        S_CCOMMIT: begin
          bit_idx <= IDX_TOP;
          if (iter_cnt == num_q) begin
            state     <= S_READOUT;
            pe_read   <= 1'b1;
            sol_valid <= 1'b1;
          end else begin
            state   <= S_LOAD;
            word_en <= 1'b0;
            pe_mode <= 1'b1;
            bit_en  <= 1'b1;
            bnd_rd  <= 1'b1;
          end
        end
        S_READOUT: begin
          if (bit_idx == '0) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pe_read   <= 1'b0;
            word_en   <= 1'b0;
            sol_valid <= 1'b0;
            bit_idx   <= IDX_TOP;
          end else begin
            bit_idx <= bit_idx - BIT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: table of whole-run vectors plus hand sequences
// for reset, ignored start, abort and the detailed two-iteration waveform.
module tb_pe_sequencer;

  logic       clka = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_iter = 8'd0;
  logic       abort = 1'b0;
  logic       busy, done, pe_mode, pe_read, bit_en, word_en, bnd_rd, sol_valid;
  logic [2:0] bit_idx;
  logic [7:0] iter_cnt;

  pe_sequencer #(.WORD_W(8), .ITER_W(8)) dut (
    .clka(clka), .rst_n(rst_n), .start(start), .num_iter(num_iter), .abort(abort),
    .busy(busy), .done(done), .pe_mode(pe_mode), .pe_read(pe_read),
    .bit_en(bit_en), .word_en(word_en), .bit_idx(bit_idx), .bnd_rd(bnd_rd),
    .sol_valid(sol_valid), .iter_cnt(iter_cnt)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic [7:0] n;
    int busy_cyc;
    int we_cnt;
    int bnd_cnt;
    int sv_cnt;
    int mode_cnt;
    int bit_cnt;
    int iter;
  } vec_t;

  int vec_count = 0;
  int miscompares = 0;

  // Per-run measurements gathered by measureRun.
  int busy_cycles, we_cnt, bnd_cnt, sv_cnt, rd_cnt, mode_cnt, bit_cnt, done_cnt;
  int overlap_err, toggle_err, idx_err, first_busy, done_cyc, done_busy;
  int we_pos[$];
  logic [63:0] mode_bits;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vec_count++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int packOutputs();
    return int'({busy, done, pe_mode, pe_read, bit_en, word_en, bnd_rd, sol_valid, bit_idx, iter_cnt});
  endfunction

  // Reset values: all strobes 0, bit_idx=7, iter_cnt=0.
  localparam int RESET_PACK = 7 << 8;

  // Called at a negedge; returns one negedge later, after start has been sampled.
  task automatic applyStimulus(input logic [7:0] n, input logic with_abort);
    start = 1'b1;
    num_iter = n;
    abort = with_abort;
    @(negedge clka);
    start = 1'b0;
    abort = 1'b0;
    num_iter = 8'd0;
  endtask

  // inject: 0 none, 1 start with num_iter=5, 2 abort; applied after sampling cycle inj_cyc.
  task automatic measureRun(input int max_cycles, input int inject, input int inj_cyc);
    int cyc = 0;
    bit seen_done = 0;
    bit prev_be = 0;
    bit prev_mode = 0;
    int exp_idx = 7;
    busy_cycles = 0; we_cnt = 0; bnd_cnt = 0; sv_cnt = 0; rd_cnt = 0; mode_cnt = 0;
    bit_cnt = 0; done_cnt = 0; overlap_err = 0; toggle_err = 0; idx_err = 0;
    first_busy = 0; done_cyc = 0; done_busy = 0; mode_bits = '0;
    we_pos.delete();
    while (!seen_done && cyc < max_cycles) begin
      @(negedge clka);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (busy) begin
        busy_cycles++;
        if (first_busy == 0) first_busy = cyc;
        if (word_en) we_pos.push_back(busy_cycles);
        if (pe_mode && busy_cycles <= 64) mode_bits[busy_cycles-1] = 1'b1;
      end
      if (word_en) we_cnt++;
      if (bnd_rd) bnd_cnt++;
      if (sol_valid) sv_cnt++;
      if (pe_read) rd_cnt++;
      if (pe_mode) mode_cnt++;
      if (bit_en) bit_cnt++;
      if (bit_en && word_en) overlap_err++;
      if (prev_be && bit_en && (prev_mode != pe_mode)) toggle_err++;
      if (bit_en || sol_valid) begin
        if (int'(bit_idx) != exp_idx) idx_err++;
        exp_idx = (exp_idx == 0) ? 7 : exp_idx - 1;
      end
      prev_be = bit_en;
      prev_mode = pe_mode;
      if (done) begin
        done_cnt++;
        seen_done = 1;
        done_cyc = cyc;
        done_busy = int'(busy);
      end
      if (cyc == inj_cyc && inject == 1) begin
        start = 1'b1;
        num_iter = 8'd5;
      end
      if (cyc == inj_cyc && inject == 2) abort = 1'b1;
    end
    if (seen_done) begin
      @(negedge clka);
      if (done) done_cnt++;
    end
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{n: 8'd1, busy_cyc: 26, we_cnt: 10, bnd_cnt: 8,  sv_cnt: 8, mode_cnt: 9,  bit_cnt: 16, iter: 1};
    vecs[1] = '{n: 8'd2, busy_cyc: 44, we_cnt: 12, bnd_cnt: 16, sv_cnt: 8, mode_cnt: 18, bit_cnt: 32, iter: 2};
    vecs[2] = '{n: 8'd0, busy_cyc: 8,  we_cnt: 8,  bnd_cnt: 0,  sv_cnt: 8, mode_cnt: 0,  bit_cnt: 0,  iter: 0};
    vecs[3] = '{n: 8'd3, busy_cyc: 62, we_cnt: 14, bnd_cnt: 24, sv_cnt: 8, mode_cnt: 27, bit_cnt: 48, iter: 3};

    // Power-on reset values.
    @(negedge clka);
    checkOutput("reset_values", packOutputs(), RESET_PACK);
    rst_n = 1'b1;
    @(negedge clka);

    // Asynchronous reset in the middle of COMP.
    applyStimulus(8'd1, 1'b0);
    repeat (12) @(negedge clka);
    checkOutput("busy_before_reset", int'(busy), 1);
    checkOutput("comp_mode_before_reset", int'(pe_mode), 0);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_values", packOutputs(), RESET_PACK);
    @(negedge clka);
    rst_n = 1'b1;
    @(negedge clka);

    // Whole-run vectors.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].n, 1'b0);
      checkOutput($sformatf("v%0d_no_bit_en_at_k", i), int'(bit_en | busy), 0);
      measureRun(200, 0, 0);
      checkOutput($sformatf("v%0d_first_busy", i), first_busy, 1);
      checkOutput($sformatf("v%0d_busy_cycles", i), busy_cycles, vecs[i].busy_cyc);
      checkOutput($sformatf("v%0d_word_en", i), we_cnt, vecs[i].we_cnt);
      checkOutput($sformatf("v%0d_bnd_rd", i), bnd_cnt, vecs[i].bnd_cnt);
      checkOutput($sformatf("v%0d_sol_valid", i), sv_cnt, vecs[i].sv_cnt);
      checkOutput($sformatf("v%0d_pe_read", i), rd_cnt, vecs[i].sv_cnt);
      checkOutput($sformatf("v%0d_pe_mode", i), mode_cnt, vecs[i].mode_cnt);
      checkOutput($sformatf("v%0d_bit_en", i), bit_cnt, vecs[i].bit_cnt);
      checkOutput($sformatf("v%0d_done_cycle", i), done_cyc, vecs[i].busy_cyc + 1);
      checkOutput($sformatf("v%0d_done_pulses", i), done_cnt, 1);
      checkOutput($sformatf("v%0d_busy_in_done", i), done_busy, 0);
      checkOutput($sformatf("v%0d_iter_cnt", i), int'(iter_cnt), vecs[i].iter);
      checkOutput($sformatf("v%0d_overlap", i), overlap_err, 0);
      checkOutput($sformatf("v%0d_mode_toggle", i), toggle_err, 0);
      checkOutput($sformatf("v%0d_bit_idx", i), idx_err, 0);
    end

    // Detailed two-iteration waveform: word_en positions and pe_mode pattern.
    begin
      int exp_we[12] = '{9, 18, 27, 36, 37, 38, 39, 40, 41, 42, 43, 44};
      applyStimulus(8'd2, 1'b0);
      measureRun(200, 0, 0);
      checkOutput("n2_we_count", we_pos.size(), 12);
      for (int i = 0; i < 12 && i < we_pos.size(); i++)
        checkOutput($sformatf("n2_we_pos%0d", i), we_pos[i], exp_we[i]);
      checkOutput("n2_mode_lo", int'(mode_bits[31:0]), 32'h07FC01FF);
      checkOutput("n2_mode_hi", int'(mode_bits[63:32]), 0);
      checkOutput("n2_done_cycle", done_cyc, 45);
    end

    // Start during COMP is ignored.
    applyStimulus(8'd1, 1'b0);
    measureRun(200, 1, 12);
    checkOutput("ign_busy_cycles", busy_cycles, 26);
    checkOutput("ign_done_pulses", done_cnt, 1);
    checkOutput("ign_iter_cnt", int'(iter_cnt), 1);
    checkOutput("ign_sol_valid", sv_cnt, 8);
    repeat (15) @(negedge clka);
    checkOutput("ign_no_late_run", int'(busy), 0);

    // Abort on the 3rd LOAD cycle of iteration 2 (busy cycle 21).
    applyStimulus(8'd3, 1'b0);
    measureRun(40, 2, 21);
    checkOutput("abort_busy_cycles", busy_cycles, 21);
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_iter_cnt", int'(iter_cnt), 1);
    checkOutput("abort_bnd_rd", bnd_cnt, 11);
    checkOutput("abort_idle_outputs", packOutputs(), (7 << 8) | 1);

    applyStimulus(8'd1, 1'b0);
    measureRun(200, 0, 0);
    checkOutput("post_abort_busy", busy_cycles, 26);
    checkOutput("post_abort_done", done_cnt, 1);
    checkOutput("post_abort_iter", int'(iter_cnt), 1);

    // Abort and start together in IDLE: nothing happens.
    applyStimulus(8'd2, 1'b1);
    measureRun(30, 0, 0);
    checkOutput("abort_start_busy", busy_cycles, 0);
    checkOutput("abort_start_done", done_cnt, 0);
    checkOutput("abort_start_iter", int'(iter_cnt), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
